vh_result_checker: RTL and testbench



---
 rtl/vh_result_checker_if.sv | 13 +
 rtl/vh_result_checker.sv | 117 +++++++++++
 tb/tb_vh_result_checker.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vh_result_checker_if.sv
// Input handshake bundle for vh_result_checker: one dut_y/ref_y pair per transfer.
// A transfer happens on a rising clk edge where in_valid && in_ready; the producer holds the pair stable while in_valid is high.
interface vh_result_checker_if #(
  parameter int Y_W = 90
);
  logic           in_valid;
  logic           in_ready;
  logic [Y_W-1:0] dut_y;
  logic [Y_W-1:0] ref_y;

  modport master (output in_valid, output dut_y, output ref_y, input in_ready);
  modport slave  (input in_valid, input dut_y, input ref_y, output in_ready);
endinterface

// File: rtl/vh_result_checker.sv
// Compares DUT y against golden y per field, counts mismatching vectors,
// records the first failure and folds dut_y into a 32-bit MISR signature.
module vh_result_checker #(
  parameter int          Y_W   = 90,
  parameter int          CNT_W = 16,
  parameter logic [31:0] POLY  = 32'h04C11DB7
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [CNT_W-1:0]     num_vec,
  vh_result_checker_if.slave   in_if,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [CNT_W-1:0]     err_count,
  output logic [CNT_W-1:0]     first_err_idx,
  output logic [17:0]          first_err_mask,
  output logic [31:0]          signature,
  output logic [1:0]           dbg_state
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   vec_idx;
  logic [CNT_W-1:0]   num_q;
  logic [Y_W-1:0]     diff;
  logic [17:0]        mask;
  logic [31:0]        fold;
  logic [31:0]        sig_next;
  logic               xfer;
  logic               start_acc;
  logic               last_vec;

  // Field widths cycle 4,5,6; field 0 sits at the top of the bus.
  function automatic int fw(input int k);
    case (k % 3)
      0:       return 4;
      1:       return 5;
      default: return 6;
    endcase
  endfunction

  function automatic int flsb(input int k);
    int s;
    s = 0;
    for (int j = k + 1; j < 18; j++) s += fw(j);
    return s;
  endfunction

  assign diff = in_if.dut_y ^ in_if.ref_y;

  for (genvar k = 0; k < 18; k++) begin : g_field
    localparam int LSB = flsb(k);
    localparam int W   = fw(k);
    assign mask[17-k] = |diff[LSB+W-1:LSB];
  end

  assign fold      = in_if.dut_y[31:0] ^ in_if.dut_y[63:32] ^ {6'b0, in_if.dut_y[89:64]};
  assign sig_next  = {signature[30:0], 1'b0} ^ (signature[31] ? POLY : 32'h0) ^ fold;
  assign xfer      = in_if.in_valid && (state_q == S_RUN);
  assign start_acc = start && (state_q != S_RUN);
  assign last_vec  = (vec_idx == num_q - 1'b1);

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: if (start) state_d = (num_vec == '0) ? S_DONE : S_RUN;
      S_RUN:          if (xfer && last_vec) state_d = S_DONE;
      default:        state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_if.in_ready = (state_q == S_RUN);
    busy           = (state_q == S_RUN);
    done           = (state_q == S_DONE);
    pass           = (state_q == S_DONE) && (err_count == '0);
    dbg_state      = state_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_count      <= '0;
      first_err_idx  <= '0;
      first_err_mask <= '0;
      signature      <= 32'hFFFFFFFF;
      vec_idx        <= '0;
      num_q          <= '0;
    end else if (start_acc) begin
      err_count      <= '0;
      first_err_idx  <= '0;
      first_err_mask <= '0;
      signature      <= 32'hFFFFFFFF;
      vec_idx        <= '0;
      num_q          <= num_vec;
    end else if (xfer) begin
      vec_idx   <= vec_idx + 1'b1;
      signature <= sig_next;
      if (mask != '0) begin
        if (err_count != '1) err_count <= err_count + 1'b1;
        // err_count only returns to zero on start/reset, so zero means no error yet this run.
        if (err_count == '0) begin
          first_err_idx  <= vec_idx;
          first_err_mask <= mask;
        end
      end
    end
  end

endmodule

// File: tb/tb_vh_result_checker.sv
// Directed bench for vh_result_checker: transfer-log model checked every cycle,
// plus literal expectations and a 4-bit-counter instance for saturation.
module tb_vh_result_checker;

  logic clk;
  logic rst;
  logic start;
  logic [15:0] num_vec;
  logic busy, done, pass;
  logic [15:0] err_count, first_err_idx;
  logic [17:0] first_err_mask;
  logic [31:0] signature;
  logic [1:0]  dbg_state;

  logic start4;
  logic [3:0] num_vec4;
  logic busy4, done4, pass4;
  logic [3:0] err_count4, first_err_idx4;
  logic [17:0] first_err_mask4;
  logic [31:0] signature4;
  logic [1:0]  dbg_state4;

  int total;
  int bad;
  bit started;

  vh_result_checker_if #(.Y_W(90)) bus ();
  vh_result_checker_if #(.Y_W(90)) bus4 ();

  vh_result_checker #(.Y_W(90), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .num_vec(num_vec), .in_if(bus),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .first_err_idx(first_err_idx), .first_err_mask(first_err_mask),
    .signature(signature), .dbg_state(dbg_state)
  );

  vh_result_checker #(.Y_W(90), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .num_vec(num_vec4), .in_if(bus4),
    .busy(busy4), .done(done4), .pass(pass4), .err_count(err_count4),
    .first_err_idx(first_err_idx4), .first_err_mask(first_err_mask4),
    .signature(signature4), .dbg_state(dbg_state4)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- model: log of accepted pairs in the current run ----------------
  logic [89:0] m_dut[$];
  logic [89:0] m_ref[$];
  int m_phase;   // 0 idle, 1 running, 2 finished
  int m_num;

  initial begin
    m_phase = 0;
    m_num   = 0;
  end

  always @(posedge clk) begin
    if (rst) begin
      m_phase = 0;
      m_dut.delete();
      m_ref.delete();
    end else if (m_phase == 1) begin
      if (bus.in_valid) begin
        m_dut.push_back(bus.dut_y);
        m_ref.push_back(bus.ref_y);
        if (m_dut.size() == m_num) m_phase = 2;
      end
    end else if (start) begin
      m_dut.delete();
      m_ref.delete();
      m_num   = int'(num_vec);
      m_phase = (num_vec == 0) ? 2 : 1;
    end
  end

  function automatic logic [17:0] field_mask(input logic [89:0] a, input logic [89:0] b);
    logic [17:0] m;
    int p;
    int w;
    m = '0;
    p = 89;
    for (int k = 0; k < 18; k++) begin
      w = (k % 3 == 0) ? 4 : ((k % 3 == 1) ? 5 : 6);
      for (int j = 0; j < w; j++)
        if (a[p-j] != b[p-j]) m[17-k] = 1'b1;
      p = p - w;
    end
    return m;
  endfunction

  function automatic logic [31:0] misr_step(input logic [31:0] s, input logic [89:0] y);
    logic [31:0] f;
    f = y[31:0] ^ y[63:32] ^ {6'b0, y[89:64]};
    return ({s[30:0], 1'b0} ^ (s[31] ? 32'h04C11DB7 : 32'h0)) ^ f;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (started) begin
      int errs;
      int fidx;
      logic [17:0] fmask;
      logic [31:0] sig;
      logic [17:0] mm;
      errs  = 0;
      fidx  = 0;
      fmask = '0;
      sig   = 32'hFFFFFFFF;
      for (int i = 0; i < m_dut.size(); i++) begin
        mm = field_mask(m_dut[i], m_ref[i]);
        if (mm != 0) begin
          if (errs == 0) begin
            fidx  = i;
            fmask = mm;
          end
          if (errs < 65535) errs++;
        end
        sig = misr_step(sig, m_dut[i]);
      end
      chk("in_ready", {31'b0, bus.in_ready}, {31'b0, m_phase == 1});
      chk("busy", {31'b0, busy}, {31'b0, m_phase == 1});
      chk("done", {31'b0, done}, {31'b0, m_phase == 2});
      chk("pass", {31'b0, pass}, {31'b0, (m_phase == 2) && (errs == 0)});
      chk("err_count", {16'b0, err_count}, 32'(errs));
      chk("first_err_idx", {16'b0, first_err_idx}, 32'(fidx));
      chk("first_err_mask", {14'b0, first_err_mask}, {14'b0, fmask});
      chk("signature", signature, sig);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [15:0] n);
    start   = 1'b1;
    num_vec = n;
    tick();
    start   = 1'b0;
    num_vec = 16'($urandom_range(0, 65535));
  endtask

  task automatic send(input logic [89:0] d, input logic [89:0] r);
    bus.in_valid = 1'b1;
    bus.dut_y    = d;
    bus.ref_y    = r;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic send4(input logic [89:0] d, input logic [89:0] r);
    bus4.in_valid = 1'b1;
    bus4.dut_y    = d;
    bus4.ref_y    = r;
    tick();
    bus4.in_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (!done && n < budget) begin
      tick();
      n++;
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL wait_done: done still %b after %0d cycles", done, budget);
    end
  endtask

  function automatic logic [89:0] rnd90();
    logic [95:0] v;
    v = {$urandom, $urandom, $urandom};
    return v[89:0];
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    logic [89:0] d;
    logic [89:0] x;
    total = 0;
    bad   = 0;
    started = 1'b0;
    rst = 1'b1;
    start = 1'b0;
    num_vec = '0;
    start4 = 1'b0;
    num_vec4 = '0;
    bus.in_valid = 1'b0;
    bus.dut_y = '0;
    bus.ref_y = '0;
    bus4.in_valid = 1'b0;
    bus4.dut_y = '0;
    bus4.ref_y = '0;
    tick();
    started = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_sig", signature, 32'hFFFFFFFF);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_pass", {31'b0, pass}, 32'd0);
    chk("rst_state", {30'b0, dbg_state}, 32'd0);

    // all-zero vectors; MISR of four zero folds from FFFFFFFF
    pulse_start(16'd4);
    for (int i = 0; i < 4; i++) send('0, '0);
    chk("t1_done", {31'b0, done}, 32'd1);
    chk("t1_pass", {31'b0, pass}, 32'd1);
    chk("t1_sig", signature, 32'hC7B0424D);
    tick();

    // vector 1 differs in field 0 and field 17
    pulse_start(16'd3);
    send('0, '0);
    d = '0;
    d[89:86] = 4'hF;
    d[5:0] = 6'h3F;
    send(d, '0);
    x = rnd90();
    send(x, x);
    chk("t2_err", {16'b0, err_count}, 32'd1);
    chk("t2_idx", {16'b0, first_err_idx}, 32'd1);
    chk("t2_mask", {14'b0, first_err_mask}, 32'h20001);
    chk("t2_pass", {31'b0, pass}, 32'd0);
    tick();

    // gapped valid with a stray start mid-run; odd vectors flip bit 40 (field 10)
    pulse_start(16'd5);
    for (int i = 0; i < 5; i++) begin
      x = rnd90();
      d = x;
      if (i % 2 == 1) d[40] = ~d[40];
      send(d, x);
      if (i == 2) begin
        start = 1'b1;
        num_vec = 16'd1;
      end
      if (i < 4) tick();
      start = 1'b0;
    end
    chk("t3_done", {31'b0, done}, 32'd1);
    chk("t3_err", {16'b0, err_count}, 32'd2);
    chk("t3_idx", {16'b0, first_err_idx}, 32'd1);
    chk("t3_mask", {14'b0, first_err_mask}, 32'h00080);
    // valid while finished is ignored
    send(rnd90(), '1);
    chk("t3_hold_err", {16'b0, err_count}, 32'd2);

    // 4-bit counters, every vector mismatching
    start4 = 1'b1;
    num_vec4 = 4'd15;
    tick();
    start4 = 1'b0;
    for (int i = 0; i < 15; i++) begin
      x = rnd90();
      send4(x, ~x);
    end
    chk("t4_done", {31'b0, done4}, 32'd1);
    chk("t4_err", {28'b0, err_count4}, 32'd15);
    chk("t4_idx", {28'b0, first_err_idx4}, 32'd0);
    chk("t4_pass", {31'b0, pass4}, 32'd0);
    tick();
    chk("t4_err_hold", {28'b0, err_count4}, 32'd15);

    // empty run
    pulse_start(16'd0);
    chk("t5_done", {31'b0, done}, 32'd1);
    chk("t5_pass", {31'b0, pass}, 32'd1);
    chk("t5_sig", signature, 32'hFFFFFFFF);
    tick();

    // reset mid-run, with a start in the reset cycle
    pulse_start(16'd6);
    send(rnd90(), '0);
    send('0, '0);
    rst = 1'b1;
    start = 1'b1;
    num_vec = 16'd2;
    tick();
    rst = 1'b0;
    start = 1'b0;
    chk("t6_state", {30'b0, dbg_state}, 32'd0);
    chk("t6_sig", signature, 32'hFFFFFFFF);
    chk("t6_err", {16'b0, err_count}, 32'd0);
    chk("t6_ready", {31'b0, bus.in_ready}, 32'd0);
    tick();
    pulse_start(16'd2);
    send(rnd90(), rnd90());
    send('0, '0);
    wait_done(4);
    chk("t6_done", {31'b0, done}, 32'd1);
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
